// File: rtl/ram_bus_master.sv
// ram_bus_master: CPU-side initiator for the 4-bit, 8-clock-frame RAM bus (SRC frame, then I/O frame).
// Defining RAM_BUS_SRC_CACHE_EN skips the SRC frame when the address matches the last one issued.
module ram_bus_master #(
   parameter logic [3:0] OP_WRM = 4'h0,
   parameter logic [3:0] OP_RDM = 4'h9
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic       req_chip,
   input  logic [1:0] req_reg,
   input  logic [3:0] req_char,
   input  logic [3:0] req_wdata,
   output logic       rsp_valid,
   output logic [3:0] rsp_rdata,
   output logic       busy,
   inout  wire  [3:0] data,
   output logic       cmd_n,
   output logic       sync
);

   localparam int unsigned CW = 3;
   localparam int unsigned AW = 7;   // {chip, reg[1:0], char[3:0]}

   typedef enum logic [1:0] {IDLE, PEND, SRC, IO} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   cycle;
   logic            last_cyc;
   logic            accept;
   logic            req_hit;
   logic            pend_hit;
   logic            drv_en;
   logic [3:0]      drv_val;
   logic [AW-1:0]   req_addr;
   logic            lat_write;
   logic [AW-1:0]   lat_addr;
   logic [3:0]      lat_wdata;

   assign req_addr = {req_chip, req_reg, req_char};
   assign last_cyc = (cycle == 3'd7);
   assign sync     = last_cyc;
   assign busy     = (state != IDLE);
   assign data     = drv_en ? drv_val : 4'bz;

   // Free-running frame counter mirrored by every RAM device
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) cycle <= '0;
      else          cycle <= CW'(cycle + 3'd1);
   end

`ifdef RAM_BUS_SRC_CACHE_EN
   logic            cache_valid;
   logic [AW-1:0]   cache_addr;
   logic            lat_hit;

   assign req_hit  = cache_valid && (cache_addr == req_addr);
   assign pend_hit = lat_hit;

   // Last address sent in an SRC frame; the RAMs keep their selection until the next one
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cache_valid <= 1'b0;
         cache_addr  <= '0;
         lat_hit     <= 1'b0;
      end else begin
         if (accept) lat_hit <= req_hit;
         if (state == SRC && last_cyc) begin
            cache_valid <= 1'b1;
            cache_addr  <= lat_addr;
         end
      end
   end
`else
   assign req_hit  = 1'b0;
   assign pend_hit = 1'b0;
`endif

   // Request capture; later req_* changes are ignored
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else if (accept) begin
         lat_write <= req_write;
         lat_addr  <= req_addr;
         lat_wdata <= req_wdata;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                                       rsp_rdata <= '0;
      else if (state == IO && cycle == 3'd6 && !lat_write) rsp_rdata <= data;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next state and combinational bus drive, keyed on state and frame cycle
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      accept    = 1'b0;
      cmd_n     = 1'b1;
      drv_en    = 1'b0;
      drv_val   = '0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept = 1'b1;
               if (last_cyc) state_nxt = req_hit ? IO : SRC;
               else          state_nxt = PEND;
            end
         end
         PEND: begin
            if (last_cyc) state_nxt = pend_hit ? IO : SRC;
         end
         SRC: begin
            if (cycle == 3'd6) begin
               cmd_n   = 1'b0;
               drv_en  = 1'b1;
               drv_val = {1'b0, lat_addr[6:4]};
            end
            if (last_cyc) begin
               drv_en    = 1'b1;
               drv_val   = lat_addr[3:0];
               state_nxt = IO;
            end
         end
         IO: begin
            if (cycle == 3'd4) begin
               cmd_n   = 1'b0;
               drv_en  = 1'b1;
               drv_val = lat_write ? OP_WRM : OP_RDM;
            end
            if (cycle == 3'd6 && lat_write) begin
               drv_en  = 1'b1;
               drv_val = lat_wdata;
            end
            if (last_cyc) begin
               rsp_valid = 1'b1;
               req_ready = 1'b1;
               state_nxt = IDLE;
               // Back-to-back accept starts the next SRC (or IO on a cache hit) with no idle frame
               if (req_valid) begin
                  accept    = 1'b1;
                  state_nxt = req_hit ? IO : SRC;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: doc/ram_bus_master.md
Name: ram_bus_master

Overview:
- CPU-side initiator for the 4-bit, 8-clock-frame RAM bus.
- Accepts single-nibble read/write requests on a valid/ready interface.
- Drives the bus through two frames: an SRC frame (chip/register/character select), then an I/O frame (WRM write or RDM read).
- Sits in the core between the execute unit and the shared `data`/`cmd_n`/`sync` bus. Owns the frame counter that all RAM devices mirror.

Parameters:
- OP_WRM, 4'h0, opcode nibble driven in I/O frame for a write
- OP_RDM, 4'h9, opcode nibble driven in I/O frame for a read

Ports:
- clock  input  1  system clock
- reset_n  input  1  reset, asynchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid && req_ready at posedge
- req_write  input  1  1=WRM, 0=RDM
- req_chip  input  1  chip select bit (matches RAM p0)
- req_reg  input  2  register address
- req_char  input  4  character address
- req_wdata  input  4  write nibble
- rsp_valid  output  1  one-clock pulse: transaction complete
- rsp_rdata  output  4  read nibble (valid with rsp_valid on reads; holds last value otherwise)
- busy  output  1  state != IDLE
- data  inout  4  shared bus; hi-z when not driving
- cmd_n  output  1  command strobe, active-low
- sync  output  1  high during cycle 7 of every frame

Behaviour:
- Clock and reset are fixed as: one clock; reset is asynchronous and active-low.
- Frame counter `cycle`[2:0]:
  - Async reset to 0, then +1 every clock, wraps 7->0.
  - Free-running regardless of requests.
  - Every RAM leaves reset on the same edge, so all counters stay in lockstep.
- `sync`:
  - Combinational, equal to (cycle==7).
  - 0 in reset.
- Bus drive is combinational from state and cycle, so each slave samples the value at the posedge where its counter equals that cycle.
- States:
  - IDLE:
    - req_ready=1.
    - On accept, latch all req_* fields.
    - If cycle==7, go to SRC; else go to PEND.
  - PEND:
    - Wait; at cycle==7, go to SRC.
  - SRC (cycle 0..7):
    - cycle 6: cmd_n=0, data={1'b0, chip, reg}.
    - cycle 7: cmd_n=1, data=char.
    - Other cycles: cmd_n=1, data hi-z.
    - At cycle 7, go to IO.
  - IO (cycle 0..7):
    - cycle 4: cmd_n=0, data=(write ? OP_WRM : OP_RDM).
    - cycle 6, write: data=wdata, cmd_n=1.
    - cycle 6, read: data hi-z, cmd_n=1, and rsp_rdata<=data sampled at that posedge.
    - cycle 7: rsp_valid=1, data hi-z, go to IDLE.
    - req_ready=1 at IO cycle 7, so a back-to-back accept goes straight to SRC with zero idle frames.
- `cmd_n` is low only at SRC cycle 6 and IO cycle 4. It must never be low at any other cycle, because RAMs decode SRC on any cmd at cycle 6.
- Latency, accept at cycle 7 to rsp_valid: 16 clocks. Accept at cycle k<7: 16+(7-k).
- Reset values:
  - req_ready=1, rsp_valid=0, rsp_rdata=0, busy=0, cmd_n=1, data hi-z, state IDLE, cycle 0.
- Reset mid-operation:
  - Bus is released immediately (async).
  - The pending transaction is dropped with no rsp_valid.
- Chip mismatch: a read returns whatever the bus floats to; the master does not detect it.
- req_* changes after accept are ignored.

Optional Feature:
- Macro: RAM_BUS_SRC_CACHE_EN.
- When defined:
  - Keep last-issued {chip, reg, char} plus a valid bit. Valid is cleared by reset.
  - On accept, if valid and the address equals the cached one, skip SRC: enter IO at the next cycle 0, directly from IDLE or PEND at cycle==7.
  - Latency becomes 8 clocks (accept at cycle 7).
  - Every SRC frame updates the cache.
- When undefined: every transaction issues SRC, and no cache registers exist.

Test Plan:
- Write: accept at cycle 7 with chip=0, reg=2, char=5, wdata=A, write=1. Required bus activity:
  - cmd_n low at exactly 2 clocks.
  - SRC c6: data=0x2. SRC c7: data=0x5.
  - IO c4: data=0x0. IO c6: data=0xA.
  - RAM model (p0=0) holds A at address 0x25.
  - rsp_valid pulses exactly 16 clocks after accept.
- Read back the same address: IO c4 drives 0x9, master hi-z at IO c6, rsp_rdata=A with rsp_valid high for exactly 1 clock.
- Request at cycle 3: PEND for 4 clocks, SRC starts at next cycle 0, rsp_valid 20 clocks after accept; req_ready=0 throughout.
- Chip mismatch, req_chip=1 vs RAM p0=0, write 0x7: RAM memory unchanged. Subsequent read with bus pull-down returns 0x0.
- Assert reset_n low at IO cycle 4: same clock, cmd_n=1 and data hi-z; no rsp_valid; cycle restarts at 0 on release.
- With RAM_BUS_SRC_CACHE_EN, two reads of address 0x25 back to back: second transaction has no SRC frame and rsp_valid 8 clocks after accept. A third read of 0x26 issues SRC (16 clocks).
